// File: rtl/share_encoder.sv
`default_nettype none
// ============================================================================
// Module   : share_encoder
// Brief    : 3-share repetition-coded masking encoder with sticky self-check.
// Revision : 1.0 - initial release
// ============================================================================
module share_encoder #(
    parameter int CODE_LEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_x,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [1:0]          port_r,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CODE_LEN-1:0] port_a_0,
    output logic [CODE_LEN-1:0] port_a_1,
    output logic [CODE_LEN-1:0] port_a_2,
    input  logic                err_clear,
    output logic                port_errorFlag_0,
    output logic                port_errorFlag_1,
    output logic                port_errorFlag_2,
    output logic                port_errorFlag_sum
);

    localparam logic [CODE_LEN-1:0] C_ONES = {CODE_LEN{1'b1}};
    localparam logic [CODE_LEN-1:0] C_ZERO = {CODE_LEN{1'b0}};

    logic                out_valid_q, out_valid_d;
    logic [CODE_LEN-1:0] port_a_0_q, port_a_0_d;
    logic [CODE_LEN-1:0] port_a_1_q, port_a_1_d;
    logic [CODE_LEN-1:0] port_a_2_q, port_a_2_d;
    logic                x_q, x_d;
    logic [3:0]          err_q, err_d;

    logic       w_free;
    logic       w_accept;
    logic [3:0] w_fault;

    always_comb begin
        w_free     = !out_valid_q || out_ready;
        w_accept   = in_valid && r_valid && w_free;
        in_ready   = r_valid && w_free;
        r_ready    = in_valid && w_free;

        out_valid_d = out_valid_q;
        port_a_0_d  = port_a_0_q;
        port_a_1_d  = port_a_1_q;
        port_a_2_d  = port_a_2_q;
        x_d         = x_q;

        if (w_accept) begin
            out_valid_d = 1'b1;
            port_a_0_d  = {CODE_LEN{in_x ^ port_r[0] ^ port_r[1]}};
            port_a_1_d  = {CODE_LEN{port_r[0]}};
            port_a_2_d  = {CODE_LEN{port_r[1]}};
            x_d         = in_x;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Bit 3 is the recombination check; bits 0..2 the per-codeword checks.
        w_fault[0] = (port_a_0_q != C_ZERO) && (port_a_0_q != C_ONES);
        w_fault[1] = (port_a_1_q != C_ZERO) && (port_a_1_q != C_ONES);
        w_fault[2] = (port_a_2_q != C_ZERO) && (port_a_2_q != C_ONES);
        w_fault[3] = (port_a_0_q[0] ^ port_a_1_q[0] ^ port_a_2_q[0]) != x_q;

        // A new fault in the same cycle as err_clear must still be recorded.
        err_d = (err_q & {4{~err_clear}}) | (w_fault & {4{out_valid_q}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            port_a_0_q  <= C_ZERO;
            port_a_1_q  <= C_ZERO;
            port_a_2_q  <= C_ZERO;
            x_q         <= 1'b0;
            err_q       <= 4'b0000;
        end else begin
            out_valid_q <= out_valid_d;
            port_a_0_q  <= port_a_0_d;
            port_a_1_q  <= port_a_1_d;
            port_a_2_q  <= port_a_2_d;
            x_q         <= x_d;
            err_q       <= err_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign port_a_0           = port_a_0_q;
    assign port_a_1           = port_a_1_q;
    assign port_a_2           = port_a_2_q;
    assign port_errorFlag_0   = err_q[0];
    assign port_errorFlag_1   = err_q[1];
    assign port_errorFlag_2   = err_q[2];
    assign port_errorFlag_sum = err_q[3];

endmodule
`default_nettype wire

// File: tb/tb_share_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_share_encoder
// Brief    : Scoreboard bench for share_encoder with random and directed traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_share_encoder;

    localparam int CL = 3;

    typedef struct {
        logic [CL-1:0] a0;
        logic [CL-1:0] a1;
        logic [CL-1:0] a2;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_x, r_valid, out_ready, err_clear;
    logic [1:0]    port_r;
    logic          in_ready, r_ready, out_valid;
    logic [CL-1:0] port_a_0, port_a_1, port_a_2;
    logic          f0, f1, f2, fsum;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;
    item_t sb[$];

    share_encoder #(.CODE_LEN(CL)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .r_valid(r_valid), .r_ready(r_ready), .port_r(port_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .port_a_0(port_a_0), .port_a_1(port_a_1), .port_a_2(port_a_2),
        .err_clear(err_clear),
        .port_errorFlag_0(f0), .port_errorFlag_1(f1),
        .port_errorFlag_2(f2), .port_errorFlag_sum(fsum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: share0 masks x with both random bits, shares 1/2 are the bits themselves.
    function automatic item_t model(input bit x, input bit [1:0] r);
        item_t it;
        it.a0 = (x ^ r[0] ^ r[1]) ? '1 : '0;
        it.a1 = r[0] ? '1 : '0;
        it.a2 = r[1] ? '1 : '0;
        return it;
    endfunction

    task automatic step(input bit iv, input bit rv, input bit x, input bit [1:0] r, input bit ordy);
        bit free, acc;
        @(negedge clk);
        in_valid = iv; r_valid = rv; in_x = x; port_r = r; out_ready = ordy;
        #1;
        free = (sb.size() == 0) || ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rv && free});
        chk("r_ready",  {31'd0, r_ready},  {31'd0, iv && free});
        acc = iv && rv && free;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(model(x, r));
    endtask

    // Monitor: compares the displayed shares against the queue head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && reset) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
                chk("flags", {28'd0, fsum, f2, f1, f0}, 32'd0);
                if (out_valid && sb.size() != 0) begin
                    chk("port_a_0", {29'd0, port_a_0}, {29'd0, sb[0].a0});
                    chk("port_a_1", {29'd0, port_a_1}, {29'd0, sb[0].a1});
                    chk("port_a_2", {29'd0, port_a_2}, {29'd0, sb[0].a2});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 0; r_valid = 0; in_x = 0; port_r = 0;
        out_ready = 0; err_clear = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_shares", {23'd0, port_a_0, port_a_1, port_a_2}, 32'd0);
        chk("rst_flags", {28'd0, fsum, f2, f1, f0}, 32'd0);
        reset = 1'b1;

        // Encode, back-pressure hold, release.
        step(1, 1, 1, 2'b10, 1);
        repeat (6) step(1, 1, 0, 2'b01, 0);
        step(1, 1, 0, 2'b01, 1);
        step(0, 0, 0, 2'b00, 1);
        // Randomness starvation then arrival.
        repeat (4) step(1, 0, 1, 2'b11, 1);
        step(1, 1, 1, 2'b11, 1);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 2'($urandom), $urandom_range(0, 9) < 7);

        step(0, 0, 0, 2'b00, 1);
        step(1, 1, 1, 2'b10, 0);
        mon_en = 1'b0;

        // Fault injection on a held output.
        @(negedge clk);
        in_valid = 0; r_valid = 0; out_ready = 0;
        force dut.port_a_1_q = 3'b010;
        @(negedge clk);
        #1;
        chk("fault_f1", {31'd0, f1}, 32'd1);
        release dut.port_a_1_q;
        force dut.port_a_0_q = 3'b111;
        @(negedge clk);
        #1;
        release dut.port_a_0_q;
        chk("fault_fsum", {31'd0, fsum}, 32'd1);
        chk("fault_f0_f2", {30'd0, f2, f0}, 32'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        chk("clear_set_wins", {30'd0, fsum, f1}, 32'h3);
        force dut.port_a_0_q = 3'b000;
        force dut.port_a_1_q = 3'b000;
        #1;
        release dut.port_a_0_q;
        release dut.port_a_1_q;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        chk("clear_flags", {28'd0, fsum, f2, f1, f0}, 32'd0);
        mon_en = 1'b1;

        // Asynchronous reset while output is held.
        step(0, 0, 0, 2'b00, 0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_shares", {23'd0, port_a_0, port_a_1, port_a_2}, 32'd0);
        chk("midrst_flags", {28'd0, fsum, f2, f1, f0}, 32'd0);
        sb.delete();
        #3;
        reset = 1'b1;

        for (int i = 0; i < 40; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        step(0, 0, 0, 2'b00, 1);
        step(0, 0, 0, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
